// File: rtl/ice_pll_mgr_pkg.sv
// Shared definitions for the iCE40 PLL manager: FSM states and the default
// divider settings (100 MHz from a 12 MHz reference).
package ice_pll_mgr_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    READY,
    FAULT
  } pll_state_e;

  localparam logic [3:0] DIVR_DEFAULT         = 4'd0;
  localparam logic [6:0] DIVF_DEFAULT         = 7'd66;
  localparam logic [2:0] DIVQ_DEFAULT         = 3'd3;
  localparam logic [2:0] FILTER_RANGE_DEFAULT = 3'd1;

endpackage

// File: rtl/ice_pll_mgr_core.sv
// Wrapper around the iCE40 PLL primitive. Without ICE40_PLL_PRIMITIVE a simple
// stand-in is elaborated whose lock rises a fixed time after RESETB releases.
module ice_pll_core
  import ice_pll_mgr_pkg::*;
#(
  parameter logic [3:0] DIVR         = DIVR_DEFAULT,
  parameter logic [6:0] DIVF         = DIVF_DEFAULT,
  parameter logic [2:0] DIVQ         = DIVQ_DEFAULT,
  parameter logic [2:0] FILTER_RANGE = FILTER_RANGE_DEFAULT
) (
  input  logic RESETB,
  input  logic REFERENCECLK,
  output logic PLLOUTCORE,
  output logic LOCK
);

`ifdef ICE40_PLL_PRIMITIVE
  SB_PLL40_CORE #(
    .FEEDBACK_PATH ("SIMPLE"),
    .PLLOUT_SELECT ("GENCLK"),
    .DIVR          (DIVR),
    .DIVF          (DIVF),
    .DIVQ          (DIVQ),
    .FILTER_RANGE  (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK    (REFERENCECLK),
    .PLLOUTCORE      (PLLOUTCORE),
    .PLLOUTGLOBAL    (),
    .EXTFEEDBACK     (1'b0),
    .DYNAMICDELAY    (8'd0),
    .LOCK            (LOCK),
    .BYPASS          (1'b0),
    .RESETB          (RESETB),
    .LATCHINPUTVALUE (1'b0),
    .SDO             (),
    .SDI             (1'b0),
    .SCLK            (1'b0)
  );
`else
  // Stand-in lock time loosely tied to the configuration so every setting is used.
  localparam int LOCK_DLY = 4 + ((int'(DIVR) + int'(DIVF) + int'(DIVQ) + int'(FILTER_RANGE)) % 8);

  logic [3:0] lock_dly_cnt;
  logic       lock_model;

  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      lock_dly_cnt <= '0;
    end else if (lock_dly_cnt != 4'(LOCK_DLY)) begin
      lock_dly_cnt <= lock_dly_cnt + 1'b1;
    end
  end

  assign lock_model = RESETB && (lock_dly_cnt == 4'(LOCK_DLY));
  assign LOCK       = lock_model;
  assign PLLOUTCORE = REFERENCECLK & RESETB;
`endif

endmodule

// File: rtl/ice_pll_mgr.sv
// PLL bring-up manager: holds the PLL in reset, waits for a stable lock with
// timeout and bounded retries, and reports ready / fault / lock-loss statistics.
module ice_pll_mgr
  import ice_pll_mgr_pkg::*;
#(
  parameter logic [3:0] DIVR                = DIVR_DEFAULT,
  parameter logic [6:0] DIVF                = DIVF_DEFAULT,
  parameter logic [2:0] DIVQ                = DIVQ_DEFAULT,
  parameter logic [2:0] FILTER_RANGE        = FILTER_RANGE_DEFAULT,
  parameter int         RST_HOLD_CYCLES     = 16,
  parameter int         LOCK_TIMEOUT_CYCLES = 4096,
  parameter int         LOCK_STABLE_CYCLES  = 256,
  parameter int         MAX_RETRIES         = 3
) (
  input  logic       pll_clk_src,
  input  logic       rst_n,
  input  logic       relock_req,
  output logic       pll_clk_out,
  output logic       PLL_LOCK,
  output logic       pll_ready,
  output logic       pll_fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock already counts as one stable cycle.
  localparam logic [STAB_W-1:0] STAB_LAST =
    STAB_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

  pll_state_e        state;
  logic              pll_resetb;
  logic              lock_raw;
  logic              lock_sync_p0;
  logic              lock_sync_p1;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [STAB_W-1:0] stab_cnt;

  ice_pll_core #(
    .DIVR         (DIVR),
    .DIVF         (DIVF),
    .DIVQ         (DIVQ),
    .FILTER_RANGE (FILTER_RANGE)
  ) u_core (
    .RESETB       (pll_resetb),
    .REFERENCECLK (pll_clk_src),
    .PLLOUTCORE   (pll_clk_out),
    .LOCK         (lock_raw)
  );

  // Stage p0/p1: two-flop synchroniser for the asynchronous raw lock
  always_ff @(posedge pll_clk_src or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_sync_p0 <= lock_raw;
      lock_sync_p1 <= lock_sync_p0;
    end
  end

  assign PLL_LOCK = lock_sync_p1;

  always_ff @(posedge pll_clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_PLL;
      pll_resetb <= 1'b0;
      pll_ready  <= 1'b0;
      pll_fault  <= 1'b0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      stab_cnt   <= '0;
    end else if (relock_req) begin
      state      <= RESET_PLL;
      pll_resetb <= 1'b0;
      pll_ready  <= 1'b0;
      pll_fault  <= 1'b0;
      retry_cnt  <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= WAIT_LOCK;
            pll_resetb <= 1'b1;
            hold_cnt   <= '0;
            to_cnt     <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (PLL_LOCK) begin
            stab_cnt <= '0;
            if (LOCK_STABLE_CYCLES <= 1) begin
              state     <= READY;
              pll_ready <= 1'b1;
              retry_cnt <= '0;
            end else begin
              state <= STABLE;
            end
          end else if (to_cnt == TO_LAST) begin
            pll_resetb <= 1'b0;
            if (retry_cnt == RETRY_MAX) begin
              state     <= FAULT;
              pll_fault <= 1'b1;
            end else begin
              state     <= RESET_PLL;
              retry_cnt <= retry_cnt + 1'b1;
              hold_cnt  <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        STABLE: begin
          // A dropout goes back to waiting but keeps the attempt's timeout budget.
          if (!PLL_LOCK) begin
            state <= WAIT_LOCK;
          end else if (stab_cnt == STAB_LAST) begin
            state     <= READY;
            pll_ready <= 1'b1;
            retry_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        READY: begin
          if (!PLL_LOCK) begin
            state      <= RESET_PLL;
            pll_resetb <= 1'b0;
            pll_ready  <= 1'b0;
            hold_cnt   <= '0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 1'b1;
          end
        end
        FAULT: begin
        end
        default: begin
          state      <= RESET_PLL;
          pll_resetb <= 1'b0;
          pll_ready  <= 1'b0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ice_pll_mgr.sv
// Directed bench for ice_pll_mgr: a rule-level model of the manager is checked
// every cycle, and literal latencies/counts pin the main scenarios.
module tb_ice_pll_mgr;

  localparam int HOLD = 4;
  localparam int TMO  = 64;
  localparam int STB  = 16;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       relock_req = 1'b0;
  logic       lock_raw = 1'b0;
  logic       pll_clk_out;
  logic       PLL_LOCK;
  logic       pll_ready;
  logic       pll_fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ice_pll_mgr #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .pll_clk_src (clk),
    .rst_n       (rst_n),
    .relock_req  (relock_req),
    .pll_clk_out (pll_clk_out),
    .PLL_LOCK    (PLL_LOCK),
    .pll_ready   (pll_ready),
    .pll_fault   (pll_fault),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  // Rule-level model: remaining hold cycles, timeout cycles spent, length of
  // the current run of synchronised lock, plus the reported status.
  bit m_s1 = 0, m_s2 = 0, m_ready = 0, m_fault = 0, m_resetb = 0;
  int m_hold = HOLD, m_waited = 0, m_run = 0, m_retry = 0, m_loss = 0;

  task automatic m_restart();
    m_hold   = HOLD;
    m_resetb = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_ready = 0; m_fault = 0; m_resetb = 0;
      m_hold = HOLD; m_waited = 0; m_run = 0; m_retry = 0; m_loss = 0;
    end else begin
      bit plock;
      plock = m_s2;
      m_s2  = m_s1;
      m_s1  = lock_raw;
      if (relock_req) begin
        m_restart();
        m_retry = 0; m_fault = 0; m_ready = 0;
      end else if (m_fault) begin
        m_resetb = 0;
      end else if (m_ready) begin
        if (!plock) begin
          if (m_loss < 255) m_loss++;
          m_ready = 0;
          m_restart();
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin m_resetb = 1; m_waited = 0; m_run = 0; end
      end else if (plock) begin
        m_run++;
        if (m_run >= STB) begin m_ready = 1; m_retry = 0; end
      end else if (m_run > 0) begin
        m_run = 0;
      end else begin
        m_waited++;
        if (m_waited >= TMO) begin
          if (m_retry == MAXR) begin m_fault = 1; m_resetb = 0; end
          else begin m_retry++; m_restart(); end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] act, req;
    act = {dut.pll_resetb, PLL_LOCK, pll_ready, pll_fault, retry_cnt, loss_cnt};
    req = {m_resetb, m_s2, m_ready, m_fault, 4'(m_retry), 8'(m_loss)};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL model_cycle t=%0t {resetb,lock,ready,fault,retry,loss} actual=%h required=%h",
               $time, act, req);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_lock(input logic v);
    lock_raw = v;
    if (v) force dut.u_core.lock_model = 1'b1;
    else   force dut.u_core.lock_model = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_resetb(input logic v, input int bound, output int n);
    n = 0;
    while (dut.pll_resetb !== v && n < bound) begin tick(); n++; end
  endtask

  task automatic wait_ready(input logic v, input int bound, output int n);
    n = 0;
    while (pll_ready !== v && n < bound) begin tick(); n++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_lock(1'b0);
    tick(2);
    check("reset_ready", pll_ready, 0);
    check("reset_fault", pll_fault, 0);
    check("reset_retry", retry_cnt, 0);
    check("reset_loss", loss_cnt, 0);
    check("reset_resetb", dut.pll_resetb, 0);

    // Clean bring-up: lock 10 cycles after RESETB release.
    rst_n = 1'b1;
    wait_resetb(1'b1, 50, n);
    check("bringup_hold", n, 4);
    tick(10);
    set_lock(1'b1);
    wait_ready(1'b1, 100, n);
    check("bringup_ready_latency", n, 18);
    check("bringup_retry", retry_cnt, 0);

    // relock_req on the same edge the lock loss is seen: loss not counted.
    set_lock(1'b0);
    tick(2);
    check("coinc_still_ready", pll_ready, 1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("coinc_ready_drop", pll_ready, 0);
    check("coinc_loss", loss_cnt, 0);
    wait_resetb(1'b1, 50, n);
    check("coinc_hold", n, 4);
    set_lock(1'b1);
    wait_ready(1'b1, 100, n);
    check("coinc_relock_ready", n, 18);

    // Repeated loss while ready: counter saturates at 255.
    for (int i = 1; i <= 300; i++) begin
      set_lock(1'b0);
      wait_ready(1'b0, 10, n);
      check("loss_ready_drop_latency", n, 3);
      wait_resetb(1'b1, 20, n);
      set_lock(1'b1);
      wait_ready(1'b1, 40, n);
    end
    check("loss_saturated", loss_cnt, 255);

    // Lock never returns: three timeouts then fault.
    set_lock(1'b0);
    wait_ready(1'b0, 10, n);
    for (int k = 1; k <= 3; k++) begin
      wait_resetb(1'b1, 20, n);
      wait_resetb(1'b0, 200, n);
      check("timeout_length", n, 64);
      if (k < 3) check("timeout_retry", retry_cnt, k);
    end
    check("fault_set", pll_fault, 1);
    check("fault_retry", retry_cnt, 2);
    tick(20);
    check("fault_held", pll_fault, 1);
    check("fault_resetb_low", dut.pll_resetb, 0);
    check("fault_clk_gated", pll_clk_out, 0);
    check("fault_loss", loss_cnt, 255);

    // relock_req out of FAULT.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_fault_clear", pll_fault, 0);
    check("relock_retry_clear", retry_cnt, 0);
    wait_resetb(1'b1, 50, n);
    check("relock_hold", n, 4);
    check("relock_loss", loss_cnt, 255);

    // 3-cycle lock glitch during STABLE.
    tick(5);
    set_lock(1'b1);
    tick(8);
    set_lock(1'b0);
    tick(3);
    set_lock(1'b1);
    wait_ready(1'b1, 100, n);
    check("glitch_ready_latency", n, 18);
    check("glitch_retry", retry_cnt, 0);

    // Asynchronous reset while ready.
    rst_n = 1'b0;
    #1;
    check("rst_ready", pll_ready, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_lock", PLL_LOCK, 0);
    check("rst_resetb", dut.pll_resetb, 0);
    tick(2);
    rst_n = 1'b1;
    wait_resetb(1'b1, 50, n);
    check("rst_release_hold", n, 4);
    wait_ready(1'b1, 100, n);
    check("rst_ready_after_hold", n, 16);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
